// File: rtl/obuft_pkg.sv
// Shared types and constants for the registered tri-state output bank.
// The channel state encoding is fixed at two bits so it stays stable across builds.
package obuft_pkg;

    typedef enum logic [1:0] {
        HIZ   = 2'd0,
        TURN  = 2'd1,
        DRIVE = 2'd2
    } chan_state_e;

    localparam int TURN_CYCLES_MAX = 255;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // A zero-cycle turnaround still needs a one-bit counter to keep the port widths legal.
    function automatic int cnt_width(input int turn_cycles);
        int w;
        w = clog2(turn_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/obuft_chan.sv
// One output channel: HIZ/TURN/DRIVE state machine, turnaround down-counter and data register.
// oe and busy decode straight from the state register so they never glitch.
module obuft_chan #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gts,
    input  logic             ce,
    input  logic             t,
    input  logic [WIDTH-1:0] d,
    output logic             oe,
    output logic             busy,
    output logic [WIDTH-1:0] dq
);
    import obuft_pkg::*;

    localparam int            CW       = cnt_width(TURN_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    chan_state_e   state;
    chan_state_e   state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HIZ;
            cnt   <= '0;
            dq    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (ce) begin
                dq <= d;
            end
        end
    end

    // Any release request or global tristate drops the channel to HIZ, so
    // an interrupted turnaround always restarts from the full count.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            HIZ: begin
                if (!t && !gts) begin
                    if (TURN_CYCLES == 0) begin
                        state_next = DRIVE;
                    end else begin
                        state_next = TURN;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            TURN: begin
                if (t || gts) begin
                    state_next = HIZ;
                end else if (cnt == '0) begin
                    state_next = DRIVE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            DRIVE: begin
                if (t || gts) begin
                    state_next = HIZ;
                end
            end
            default: begin
                state_next = HIZ;
            end
        endcase
    end

    assign oe   = (state == DRIVE);
    assign busy = (state == TURN);

endmodule

// File: rtl/obuft_bank.sv
// Bank of independent registered tri-state output channels with bus-turnaround
// dead time and a global tristate that floats every pad combinationally.
module obuft_bank #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic                        C,
    input  logic                        R_N,
    input  logic                        GTS,
    input  logic                        CE,
    input  logic [CHANNELS*WIDTH-1:0]   I,
    input  logic [CHANNELS-1:0]         T,
    output tri logic [CHANNELS*WIDTH-1:0] O,
    output logic [CHANNELS-1:0]         OE,
    output logic [CHANNELS-1:0]         BUSY
);
    import obuft_pkg::*;

    if (TURN_CYCLES > TURN_CYCLES_MAX || TURN_CYCLES < 0 || WIDTH < 1 || CHANNELS < 1) begin : g_bad_params
        $fatal(1, "obuft_bank: illegal parameters WIDTH=%0d CHANNELS=%0d TURN_CYCLES=%0d",
               WIDTH, CHANNELS, TURN_CYCLES);
    end

    // GTS gates the pads directly so they float in the same cycle it rises.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        logic [WIDTH-1:0] dq;

        obuft_chan #(
            .WIDTH       (WIDTH),
            .TURN_CYCLES (TURN_CYCLES)
        ) u_chan (
            .clk   (C),
            .rst_n (R_N),
            .gts   (GTS),
            .ce    (CE),
            .t     (T[k]),
            .d     (I[k*WIDTH +: WIDTH]),
            .oe    (OE[k]),
            .busy  (BUSY[k]),
            .dq    (dq)
        );

        assign O[k*WIDTH +: WIDTH] = (OE[k] && !GTS) ? dq : {WIDTH{1'bz}};
    end

endmodule
